// File: rtl/approx_rca_qos_ctrl.sv
// Closed-loop QoS controller for a 4-bit dynamic-mode ripple-carry adder: registers operands onto
// the adder, returns {Cout,Sum} with its error, adapts the mode per window. APPROX_QOS_STATS_EN adds stats.
module approx_rca_qos_ctrl #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned ERR_HI = 32,
  parameter int unsigned ERR_LO = 8,
  parameter int unsigned ACC_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_cin,
  output logic [3:0]       rca_a,
  output logic [3:0]       rca_b,
  output logic             rca_cin,
  output logic [1:0]       rca_mode,
  input  logic [3:0]       rca_sum,
  input  logic             rca_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_sum,
  output logic [4:0]       out_err,
  output logic [1:0]       out_mode,
  input  logic             cfg_force_en,
  input  logic [1:0]       cfg_force_mode
`ifdef APPROX_QOS_STATS_EN
  ,
  output logic [7:0]       stat_changes,
  output logic [ACC_W-1:0] stat_last_err
`endif
);

  localparam int unsigned CntW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned SumW = ((ACC_W > 5) ? ACC_W : 5) + 1;
  localparam logic [SumW-1:0] AccMax = SumW'({ACC_W{1'b1}});

  typedef enum logic [1:0] {StRun, StCooldown, StForced} state_e;

  state_e          state_q, state_d;
  logic            s1_valid_q, s1_valid_d;
  logic [3:0]      rca_a_q, rca_a_d, rca_b_q, rca_b_d;
  logic            rca_cin_q, rca_cin_d;
  logic [1:0]      mode_q, mode_d;
  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_sum_q, out_sum_d, out_err_q, out_err_d;
  logic [1:0]      out_mode_q, out_mode_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_n;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            s1_adv, in_fire, win_end, adapt_chg;
  logic [4:0]      approx, exact, err;
  logic [SumW-1:0] acc_sum;

  assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;

  assign approx  = {rca_cout, rca_sum};
  assign exact   = {1'b0, rca_a_q} + {1'b0, rca_b_q} + {4'b0000, rca_cin_q};
  assign err     = (exact >= approx) ? (exact - approx) : (approx - exact);
  assign acc_sum = SumW'(acc_q) + SumW'(err);
  assign acc_n   = (acc_sum > AccMax) ? AccMax[ACC_W-1:0] : acc_sum[ACC_W-1:0];
  assign win_end = s1_adv && (cnt_q == CntW'(WINDOW - 1));

  always_comb begin : datapath
    s1_valid_d  = s1_valid_q;
    rca_a_d     = rca_a_q;
    rca_b_d     = rca_b_q;
    rca_cin_d   = rca_cin_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_err_d   = out_err_q;
    out_mode_d  = out_mode_q;
    if (s1_adv) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b1;
      out_sum_d   = approx;
      out_err_d   = err;
      out_mode_d  = mode_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      rca_a_d    = in_a;
      rca_b_d    = in_b;
      rca_cin_d  = in_cin;
    end
  end

  always_comb begin : ctrl
    state_d   = state_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    adapt_chg = 1'b0;
    if (cfg_force_en) begin
      // Force overrides adaptation, including a coincident window end.
      state_d = StForced;
      mode_d  = cfg_force_mode;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == StForced) state_d = StCooldown;
      if (win_end) begin
        acc_d = '0;
        cnt_d = '0;
        if (state_q == StRun) begin
          if ((32'(acc_n) > ERR_HI) && (mode_q != 2'd0)) begin
            mode_d    = mode_q - 2'd1;
            state_d   = StCooldown;
            adapt_chg = 1'b1;
          end else if ((32'(acc_n) < ERR_LO) && (mode_q != 2'd3)) begin
            mode_d    = mode_q + 2'd1;
            state_d   = StCooldown;
            adapt_chg = 1'b1;
          end
        end else if (state_q == StCooldown) begin
          state_d = StRun;
        end
      end else if (s1_adv) begin
        acc_d = acc_n;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      s1_valid_q  <= 1'b0;
      rca_a_q     <= '0;
      rca_b_q     <= '0;
      rca_cin_q   <= 1'b0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_err_q   <= '0;
      out_mode_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      rca_a_q     <= rca_a_d;
      rca_b_q     <= rca_b_d;
      rca_cin_q   <= rca_cin_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_err_q   <= out_err_d;
      out_mode_q  <= out_mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rca_a     = rca_a_q;
  assign rca_b     = rca_b_q;
  assign rca_cin   = rca_cin_q;
  assign rca_mode  = mode_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;
  assign out_mode  = out_mode_q;

`ifdef APPROX_QOS_STATS_EN
  logic [7:0]       stat_changes_q, stat_changes_d;
  logic [ACC_W-1:0] stat_last_err_q, stat_last_err_d;

  always_comb begin
    stat_changes_d  = stat_changes_q;
    stat_last_err_d = stat_last_err_q;
    if (adapt_chg && (stat_changes_q != 8'hFF)) stat_changes_d = stat_changes_q + 8'd1;
    if (win_end && !cfg_force_en) stat_last_err_d = acc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_changes_q  <= '0;
      stat_last_err_q <= '0;
    end else begin
      stat_changes_q  <= stat_changes_d;
      stat_last_err_q <= stat_last_err_d;
    end
  end

  assign stat_changes  = stat_changes_q;
  assign stat_last_err = stat_last_err_q;
`endif

endmodule
